// File: rtl/hazard_control.sv
// Load-use, branch-operand and mult/div hazard controller with HI/LO sequencer.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_control #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        branchD,
  input  logic        jrD,
  input  logic        pcsrcD,
  input  logic        mfhiloD,
  input  logic        mdstartD,
  input  logic [4:0]  writeregE,
  input  logic        regwriteE,
  input  logic        memtoregE,
  input  logic        mdstartE,
  input  logic        mddivE,
  input  logic [4:0]  writeregM,
  input  logic        memtoregM,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        md_busy,
  output logic        md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } md_state_e;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);
  localparam logic             MULT_ONE = (MULT_LAT == 1);
  localparam logic             DIV_ONE  = (DIV_LAT == 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_nz, rt_nz;
  logic lw_stall, br_stall, md_stall, stall;
  logic rs_br_hit, rt_br_hit;

  // $0 never matches anything
  always_comb begin
    rs_nz     = (rsD != 5'd0);
    rt_nz     = (rtD != 5'd0);
    lw_stall  = memtoregE & (
                  (rs_nz & (writeregE == rsD)) |
                  (rt_nz & (writeregE == rtD)));
    rs_br_hit = rs_nz & (
                  (regwriteE & (writeregE == rsD)) |
                  (memtoregM & (writeregM == rsD)));
    rt_br_hit = rt_nz & (
                  (regwriteE & (writeregE == rtD)) |
                  (memtoregM & (writeregM == rtD)));
    br_stall  = ((branchD | jrD) & rs_br_hit) |
                (branchD & rt_br_hit);
    md_stall  = (mfhiloD | mdstartD) & md_busy & ~md_done;
    stall     = lw_stall | br_stall | md_stall;
  end

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = pcsrcD & ~stall;

  logic             lat_one;
  logic [CNT_W-1:0] load_cnt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_one  = mddivE ? DIV_ONE : MULT_ONE;
    load_cnt = mddivE ? DIV_CNT : MULT_CNT;
    unique case (state_q)
      S_IDLE: begin
        if (mdstartE) begin
          cnt_d   = load_cnt;
          state_d = lat_one ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        // a new issue here is a protocol error and is dropped
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (mdstartE) begin
          cnt_d   = load_cnt;
          state_d = lat_one ? S_DONE : S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_busy = (state_q != S_IDLE);
  assign md_done = (state_q == S_DONE);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flushD && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control; expected outputs come from a
// cycle-numbered model of the mult/div latency and the hazard equations.
module tb_hazard_control;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, writeregE, writeregM;
  logic       branchD, jrD, pcsrcD, mfhiloD, mdstartD;
  logic       regwriteE, memtoregE, mdstartE, mddivE, memtoregM;
  logic       stallF, stallD, flushD, flushE, md_busy, md_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  always #5 clk = ~clk;

  hazard_control #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (6)
  ) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD),
    .branchD(branchD), .jrD(jrD),
    .pcsrcD(pcsrcD), .mfhiloD(mfhiloD),
    .mdstartD(mdstartD),
    .writeregE(writeregE),
    .regwriteE(regwriteE),
    .memtoregE(memtoregE),
    .mdstartE(mdstartE), .mddivE(mddivE),
    .writeregM(writeregM),
    .memtoregM(memtoregM),
    .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE),
    .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  typedef struct packed {
    logic       reset;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       branchD;
    logic       jrD;
    logic       pcsrcD;
    logic       mfhiloD;
    logic       mdstartD;
    logic [4:0] writeregE;
    logic       regwriteE;
    logic       memtoregE;
    logic       mdstartE;
    logic       mddivE;
    logic [4:0] writeregM;
    logic       memtoregM;
  } stim_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] sb_q[$];

  int cyc = 0;
  bit act = 0;
  int iss_c = 0;
  int done_c = 0;
  int stall_n = 0;
  int flush_n = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit src_hit(input logic [4:0] r,
                                 input stim_t s);
    if (r == 5'd0) return 1'b0;
    return (s.regwriteE && s.writeregE == r) ||
           (s.memtoregM && s.writeregM == r);
  endfunction

  task automatic run(input stim_t s, input string tag);
    bit lw, br, md, st, fl, be, de;
    logic [5:0] got;
    logic [5:0] exp;
    @(posedge clk);
    cyc++;
    #1;
    reset     = s.reset;
    rsD       = s.rsD;
    rtD       = s.rtD;
    branchD   = s.branchD;
    jrD       = s.jrD;
    pcsrcD    = s.pcsrcD;
    mfhiloD   = s.mfhiloD;
    mdstartD  = s.mdstartD;
    writeregE = s.writeregE;
    regwriteE = s.regwriteE;
    memtoregE = s.memtoregE;
    mdstartE  = s.mdstartE;
    mddivE    = s.mddivE;
    writeregM = s.writeregM;
    memtoregM = s.memtoregM;
    if (s.reset) act = 0;
    be = act && cyc > iss_c && cyc <= done_c;
    de = act && cyc == done_c;
    lw = s.memtoregE && s.writeregE != 5'd0 &&
         (s.writeregE == s.rsD || s.writeregE == s.rtD);
    br = ((s.branchD || s.jrD) && src_hit(s.rsD, s)) ||
         (s.branchD && src_hit(s.rtD, s));
    md = (s.mfhiloD || s.mdstartD) && be && !de;
    st = lw || br || md;
    fl = s.pcsrcD && !st;
    sb_q.push_back({st, st, fl, st, be, de});
    if (!s.reset) begin
      stall_n += int'(st);
      flush_n += int'(fl);
      if (s.mdstartE && (!be || de)) begin
        act    = 1;
        iss_c  = cyc;
        done_c = cyc + (s.mddivE ? DIV_LAT : MULT_LAT);
      end
    end else begin
      stall_n = 0;
      flush_n = 0;
    end
    @(negedge clk);
    got = {stallF, stallD, flushD, flushE, md_busy, md_done};
    exp = sb_q.pop_front();
    chk(tag, 32'(got), 32'(exp));
  endtask

  stim_t s;

  initial begin
    reset = 1'b1;
    {rsD, rtD, writeregE, writeregM} = '0;
    {branchD, jrD, pcsrcD, mfhiloD, mdstartD} = '0;
    {regwriteE, memtoregE, mdstartE, mddivE, memtoregM} = '0;

    s = '0; s.reset = 1'b1;
    run(s, "reset");
    s = '0;
    run(s, "idle");

    s = '0; s.memtoregE = 1; s.writeregE = 5'd8; s.rsD = 5'd8;
    run(s, "lw_rs");
    s = '0;
    run(s, "lw_clear");
    s = '0; s.memtoregE = 1; s.writeregE = 5'd9; s.rtD = 5'd9;
    run(s, "lw_rt");
    s = '0; s.memtoregE = 1;
    run(s, "lw_r0");

    s = '0; s.branchD = 1; s.rtD = 5'd9; s.pcsrcD = 1;
    s.regwriteE = 1; s.writeregE = 5'd9;
    run(s, "beq_stall");
    s.regwriteE = 0; s.writeregE = 5'd0;
    run(s, "beq_redir");
    s = '0; s.branchD = 1; s.rsD = 5'd7;
    s.memtoregM = 1; s.writeregM = 5'd7;
    run(s, "beq_ldM");

    s = '0; s.jrD = 1; s.regwriteE = 1;
    run(s, "jr_r0");
    s = '0; s.jrD = 1; s.rsD = 5'd3; s.rtD = 5'd5;
    s.regwriteE = 1; s.writeregE = 5'd5;
    run(s, "jr_rt");
    s.writeregE = 5'd3;
    run(s, "jr_rs");

    s = '0; s.mdstartE = 1; s.mddivE = 1; s.mfhiloD = 1;
    run(s, "div_iss");
    s.mdstartE = 0;
    for (int i = 1; i <= 33; i++) run(s, $sformatf("div_t%0d", i));

    s = '0; s.mdstartE = 1;
    run(s, "mul_iss");
    s = '0; s.mfhiloD = 1;
    run(s, "mul_t1");
    s.reset = 1;
    run(s, "mul_rst");
    s.reset = 0;
    for (int i = 3; i <= 7; i++) run(s, $sformatf("mul_t%0d", i));

    s = '0; s.mdstartE = 1;
    run(s, "mul2_iss");
    s = '0;
    for (int i = 1; i < MULT_LAT; i++) run(s, "mul2_wait");
    s.mdstartE = 1; s.mddivE = 1;
    run(s, "mul2_done_rel");
    s = '0; s.mdstartE = 1;
    run(s, "busy_issue_drop");

    for (int i = 0; i < 300; i++) begin
      s = '0;
      s.reset     = ($urandom_range(0, 59) == 0);
      s.rsD       = 5'($urandom_range(0, 3));
      s.rtD       = 5'($urandom_range(0, 3));
      s.branchD   = 1'($urandom_range(0, 1));
      s.jrD       = !s.branchD && ($urandom_range(0, 3) == 0);
      s.pcsrcD    = 1'($urandom_range(0, 1));
      s.mfhiloD   = ($urandom_range(0, 3) == 0);
      s.mdstartD  = ($urandom_range(0, 5) == 0);
      s.writeregE = 5'($urandom_range(0, 3));
      s.regwriteE = 1'($urandom_range(0, 1));
      s.memtoregE = ($urandom_range(0, 3) == 0);
      s.mdstartE  = ($urandom_range(0, 5) == 0);
      s.mddivE    = ($urandom_range(0, 3) == 0);
      s.writeregM = 5'($urandom_range(0, 3));
      s.memtoregM = 1'($urandom_range(0, 1));
      run(s, "rand");
    end

`ifdef HAZARD_PERF_EN
    s = '0; s.reset = 1;
    run(s, "perf_rst");
    s = '0; s.memtoregE = 1; s.writeregE = 5'd4; s.rsD = 5'd4;
    for (int i = 0; i < 3; i++) begin
      run(s, "perf_lw");
      run('0, "perf_gap");
    end
    s = '0; s.pcsrcD = 1;
    run(s, "perf_redir");
    run('0, "perf_gap");
    run(s, "perf_redir");
    run('0, "perf_end");
    @(posedge clk);
    #1;
    chk("perf_stall_model", stall_cycles, 32'(stall_n));
    chk("perf_flush_model", flush_cycles, 32'(flush_n));
    chk("perf_stall_3", stall_cycles, 32'd3);
    chk("perf_flush_2", flush_cycles, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
